el2_dccm_init_ctl: RTL and testbench
====================================

Name: el2_dccm_init_ctl

Overview:
- Sits directly upstream of the DCCM write/read ports of the memory wrapper, between the LSU DCCM request lines and the wrapper inputs.
- After reset, or on request, it sweeps the whole DCCM and writes an all-zero full-width word to every location. The all-zero word is a valid SECDED codeword for zero data, so later loads never take spurious ECC errors on uninitialised SRAM.
- While sweeping, it owns the DCCM ports and stalls the LSU. Otherwise it is a transparent pass-through.

Parameters:
- DCCM_BITS, 16, byte-address width of the DCCM; DCCM size is 2^DCCM_BITS bytes.
- DCCM_FDATA_WIDTH, 39, full word width (32 data + 7 ECC).
- AUTO_INIT, 1, 1 = sweep starts automatically after reset; 0 = wait for init_start.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; asynchronous, active-low.
- init_start  in  1  single-cycle request to (re)initialise the DCCM.
- lsu_dccm_wren  in  1  LSU write request.
- lsu_dccm_rden  in  1  LSU read request.
- lsu_dccm_wr_addr_lo  in  DCCM_BITS  LSU write address, lo word.
- lsu_dccm_wr_addr_hi  in  DCCM_BITS  LSU write address, hi word.
- lsu_dccm_rd_addr_lo  in  DCCM_BITS  LSU read address, lo word.
- lsu_dccm_rd_addr_hi  in  DCCM_BITS  LSU read address, hi word.
- lsu_dccm_wr_data_lo  in  DCCM_FDATA_WIDTH  LSU write data, lo word.
- lsu_dccm_wr_data_hi  in  DCCM_FDATA_WIDTH  LSU write data, hi word.
- dccm_wren  out  1  to memory wrapper.
- dccm_rden  out  1  to memory wrapper.
- dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi  out  DCCM_BITS each  to memory wrapper.
- dccm_wr_data_lo, dccm_wr_data_hi  out  DCCM_FDATA_WIDTH each  to memory wrapper.
- lsu_dccm_stall  out  1  LSU must hold its request; request is not forwarded.
- init_busy  out  1  sweep in progress.
- init_done  out  1  at least one full sweep has completed since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_l is asynchronous and active-low.
- FSM states: RST, IDLE, INIT, DONE. State register and sweep pointer ptr[DCCM_BITS-1:0] reset asynchronously to RST and 0.
- RST:
  - Outputs: dccm_wren=0, dccm_rden=0, all addresses and data 0, init_busy=0, init_done=0, lsu_dccm_stall=1.
  - Next state is INIT if AUTO_INIT=1, else IDLE. This gives exactly one cycle in RST after rst_l deasserts.
- IDLE:
  - Pass-through: every dccm_* output equals its lsu_dccm_* counterpart combinationally.
  - lsu_dccm_stall=0.
  - init_start=1 moves to INIT with ptr=0.
- INIT:
  - Every cycle drives dccm_wren=1, dccm_rden=0, dccm_wr_addr_lo=ptr, dccm_wr_addr_hi=ptr+4, both write data = 0.
  - Read addresses are driven to 0. lsu_dccm_stall=1 and init_busy=1.
  - ptr advances by 8 per cycle; two 32-bit words are written per cycle.
  - When ptr == 2^DCCM_BITS-8, that cycle performs the last write. The FSM then goes to DONE, ptr wraps to 0, and init_done sets on the next edge.
  - Sweep length is 2^(DCCM_BITS-3) cycles.
  - LSU requests arriving in INIT are not forwarded and are not dropped by this block; the LSU holds them while lsu_dccm_stall=1.
  - init_start during INIT is ignored; the sweep does not restart.
- DONE:
  - Same pass-through as IDLE; init_done=1 and stays set until reset.
  - init_start=1 re-enters INIT with ptr=0, and init_done remains 1.
- Simultaneous init_start and LSU request in IDLE/DONE: the LSU request in that cycle passes through. INIT begins on the next cycle.
- Reset mid-sweep: state returns to RST and ptr to 0 asynchronously. A new full sweep follows if AUTO_INIT=1.
- Address arithmetic: modulo 2^DCCM_BITS. ptr+4 never overflows because ptr ≤ 2^DCCM_BITS-8.
- Pass-through path has zero added latency. All init-path outputs derive from registered state/ptr.

Test Plan:
- DCCM_BITS=6, AUTO_INIT=1: release rst_l → 1 cycle RST, then 8 INIT cycles writing lo addresses 0x00,0x08,…,0x38 and hi addresses 0x04,…,0x3C, data 0. init_done=1 from the cycle after the last write.
- Reset sequencing: hold rst_l=0 → all dccm_* outputs 0, lsu_dccm_stall=1, init_busy=0.
- AUTO_INIT=0: rst_l released, LSU write to 0x10 with data 0x12345 → dccm_wren=1, dccm_wr_addr_lo=0x10 in the same cycle. Pulse init_start → 8-cycle sweep.
- LSU read asserted during INIT → dccm_rden=0 and lsu_dccm_stall=1 every INIT cycle. The held read appears on dccm_rden in the first DONE cycle.
- Assert rst_l=0 at sweep cycle 3, release → ptr restarts at 0, the full 8-cycle sweep repeats, and init_done stays 0 until it completes.
- init_start pulsed in INIT cycle 2 → sweep still ends after 8 cycles. init_start in DONE → second sweep starts at 0x00 with init_done held at 1.

Source files
------------

// File: rtl/el2_dccm_init_ctl.sv
// DCCM initialisation controller.
// After reset, or when init_start is pulsed, this block walks the whole DCCM
// and writes an all-zero word to every location. All-zero is a valid SECDED
// codeword for zero data, so later loads never see ECC errors from
// uninitialised SRAM. While the sweep runs, the block owns the DCCM ports and
// stalls the LSU. At all other times the LSU request lines pass straight
// through to the memory wrapper with no added latency.
module el2_dccm_init_ctl #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter bit AUTO_INIT        = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        init_start,
  input  logic                        lsu_dccm_wren,
  input  logic                        lsu_dccm_rden,
  input  logic [DCCM_BITS-1:0]        lsu_dccm_wr_addr_lo,
  input  logic [DCCM_BITS-1:0]        lsu_dccm_wr_addr_hi,
  input  logic [DCCM_BITS-1:0]        lsu_dccm_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]        lsu_dccm_rd_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] lsu_dccm_wr_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] lsu_dccm_wr_data_hi,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic                        lsu_dccm_stall,
  output logic                        init_busy,
  output logic                        init_done
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_INIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Each sweep cycle writes two adjacent 32-bit words (lo at ptr, hi at ptr+4),
  // so the pointer moves 8 bytes per cycle and its low three bits stay zero.
  localparam logic [DCCM_BITS-1:0] PTR_STEP   = DCCM_BITS'(8);
  localparam logic [DCCM_BITS-1:0] PTR_HI_OFS = DCCM_BITS'(4);
  localparam logic [DCCM_BITS-1:0] PTR_LAST   = {{(DCCM_BITS-3){1'b1}}, 3'b000};

  state_t                 state;
  state_t                 state_nxt;
  logic [DCCM_BITS-1:0]   ptr;
  logic [DCCM_BITS-1:0]   ptr_nxt;
  logic                   done_q;
  logic                   done_nxt;
  logic                   last_write;

  // The sweep finishes on the cycle that writes the top 8-byte pair.
  assign last_write = (state == ST_INIT) && (ptr == PTR_LAST);

  // State register, sweep pointer and sticky completion flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= ST_RST;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state logic: leave RST after one cycle, start a sweep on request,
  // advance the pointer while sweeping and latch completion on the last write.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = done_q;
    unique case (state)
      ST_RST: begin
        state_nxt = AUTO_INIT ? ST_INIT : ST_IDLE;
        ptr_nxt   = '0;
      end
      ST_IDLE, ST_DONE: begin
        if (init_start) begin
          state_nxt = ST_INIT;
          ptr_nxt   = '0;
        end
      end
      ST_INIT: begin
        // init_start is deliberately ignored here; a sweep never restarts.
        // The increment wraps the pointer back to 0 after the last write.
        ptr_nxt = ptr + PTR_STEP;
        if (last_write) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RST;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Output mux: drive the sweep write from registered ptr, pass the LSU through
  // when idle/done, and hold everything quiet with the LSU stalled in RST.
  always_comb begin
    dccm_wren       = 1'b0;
    dccm_rden       = 1'b0;
    dccm_wr_addr_lo = '0;
    dccm_wr_addr_hi = '0;
    dccm_rd_addr_lo = '0;
    dccm_rd_addr_hi = '0;
    dccm_wr_data_lo = '0;
    dccm_wr_data_hi = '0;
    lsu_dccm_stall  = 1'b1;
    init_busy       = 1'b0;
    init_done       = done_q;
    unique case (state)
      ST_RST: begin
        init_done = 1'b0;
      end
      ST_IDLE, ST_DONE: begin
        // A request coinciding with init_start still passes through this cycle.
        dccm_wren       = lsu_dccm_wren;
        dccm_rden       = lsu_dccm_rden;
        dccm_wr_addr_lo = lsu_dccm_wr_addr_lo;
        dccm_wr_addr_hi = lsu_dccm_wr_addr_hi;
        dccm_rd_addr_lo = lsu_dccm_rd_addr_lo;
        dccm_rd_addr_hi = lsu_dccm_rd_addr_hi;
        dccm_wr_data_lo = lsu_dccm_wr_data_lo;
        dccm_wr_data_hi = lsu_dccm_wr_data_hi;
        lsu_dccm_stall  = 1'b0;
      end
      ST_INIT: begin
        // Write data stays at the all-zero default; reads are suppressed.
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = ptr;
        dccm_wr_addr_hi = ptr + PTR_HI_OFS;
        init_busy       = 1'b1;
      end
      default: begin
        init_done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_el2_dccm_init_ctl.sv
// Bench for el2_dccm_init_ctl with a 64-byte DCCM (8-cycle sweep). Two copies
// run side by side on shared stimulus: index 0 with AUTO_INIT=1, index 1 with
// AUTO_INIT=0. Each cycle both are compared against a reference model that
// tracks "cycles since reset", "position in sweep" and "has ever finished".
module tb_el2_dccm_init_ctl;

  localparam int DB     = 6;
  localparam int FW     = 39;
  localparam int NSWEEP = (1 << DB) / 8;

  typedef struct packed {
    logic          wren;
    logic          rden;
    logic [DB-1:0] wa_lo;
    logic [DB-1:0] wa_hi;
    logic [DB-1:0] ra_lo;
    logic [DB-1:0] ra_hi;
    logic [FW-1:0] wd_lo;
    logic [FW-1:0] wd_hi;
    logic          stall;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          init_start = 1'b0;
  logic          l_wren = 1'b0;
  logic          l_rden = 1'b0;
  logic [DB-1:0] l_wa_lo = '0;
  logic [DB-1:0] l_wa_hi = '0;
  logic [DB-1:0] l_ra_lo = '0;
  logic [DB-1:0] l_ra_hi = '0;
  logic [FW-1:0] l_wd_lo = '0;
  logic [FW-1:0] l_wd_hi = '0;

  logic          d_wren  [2];
  logic          d_rden  [2];
  logic [DB-1:0] d_wa_lo [2];
  logic [DB-1:0] d_wa_hi [2];
  logic [DB-1:0] d_ra_lo [2];
  logic [DB-1:0] d_ra_hi [2];
  logic [FW-1:0] d_wd_lo [2];
  logic [FW-1:0] d_wd_hi [2];
  logic          d_stall [2];
  logic          d_busy  [2];
  logic          d_done  [2];
  obs_t          obs     [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state per instance.
  bit m_rst  [2];   // in the single post-reset cycle (or reset held)
  int m_pos  [2];   // sweep index 0..NSWEEP-1, or -1 when not sweeping
  bit m_done [2];   // a full sweep has completed since reset

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    el2_dccm_init_ctl #(
      .DCCM_BITS       (DB),
      .DCCM_FDATA_WIDTH(FW),
      .AUTO_INIT       (g == 0)
    ) u_dut (
      .clk                (clk),
      .rst_l              (rst_l),
      .init_start         (init_start),
      .lsu_dccm_wren      (l_wren),
      .lsu_dccm_rden      (l_rden),
      .lsu_dccm_wr_addr_lo(l_wa_lo),
      .lsu_dccm_wr_addr_hi(l_wa_hi),
      .lsu_dccm_rd_addr_lo(l_ra_lo),
      .lsu_dccm_rd_addr_hi(l_ra_hi),
      .lsu_dccm_wr_data_lo(l_wd_lo),
      .lsu_dccm_wr_data_hi(l_wd_hi),
      .dccm_wren          (d_wren[g]),
      .dccm_rden          (d_rden[g]),
      .dccm_wr_addr_lo    (d_wa_lo[g]),
      .dccm_wr_addr_hi    (d_wa_hi[g]),
      .dccm_rd_addr_lo    (d_ra_lo[g]),
      .dccm_rd_addr_hi    (d_ra_hi[g]),
      .dccm_wr_data_lo    (d_wd_lo[g]),
      .dccm_wr_data_hi    (d_wd_hi[g]),
      .lsu_dccm_stall     (d_stall[g]),
      .init_busy          (d_busy[g]),
      .init_done          (d_done[g])
    );
    assign obs[g] = {d_wren[g], d_rden[g], d_wa_lo[g], d_wa_hi[g], d_ra_lo[g],
                     d_ra_hi[g], d_wd_lo[g], d_wd_hi[g], d_stall[g], d_busy[g],
                     d_done[g]};
  end

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected outputs for instance k given current model state and inputs.
  function automatic obs_t expect_out(input int k);
    obs_t e;
    e       = '0;
    e.stall = 1'b1;
    if (!rst_l || m_rst[k]) return e;
    e.done = m_done[k];
    if (m_pos[k] >= 0) begin
      e.wren  = 1'b1;
      e.wa_lo = DB'(m_pos[k] * 8);
      e.wa_hi = DB'(m_pos[k] * 8 + 4);
      e.busy  = 1'b1;
    end else begin
      e.wren  = l_wren;
      e.rden  = l_rden;
      e.wa_lo = l_wa_lo;
      e.wa_hi = l_wa_hi;
      e.ra_lo = l_ra_lo;
      e.ra_hi = l_ra_hi;
      e.wd_lo = l_wd_lo;
      e.wd_hi = l_wd_hi;
      e.stall = 1'b0;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rst[k]  = 1'b1;
      m_pos[k]  = -1;
      m_done[k] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_l) begin
        m_rst[k]  = 1'b1;
        m_pos[k]  = -1;
        m_done[k] = 1'b0;
      end else if (m_rst[k]) begin
        m_rst[k] = 1'b0;
        m_pos[k] = (k == 0) ? 0 : -1;
      end else if (m_pos[k] >= 0) begin
        if (m_pos[k] == NSWEEP - 1) begin
          m_pos[k]  = -1;
          m_done[k] = 1'b1;
        end else begin
          m_pos[k] = m_pos[k] + 1;
        end
      end else if (init_start) begin
        m_pos[k] = 0;
      end
    end
  endtask

  task automatic randomize_lsu();
    l_wren  = 1'($urandom);
    l_rden  = 1'($urandom);
    l_wa_lo = DB'($urandom);
    l_wa_hi = DB'($urandom);
    l_ra_lo = DB'($urandom);
    l_ra_hi = DB'($urandom);
    l_wd_lo = FW'({$urandom, $urandom});
    l_wd_hi = FW'({$urandom, $urandom});
  endtask

  task automatic check_both(input string tag);
    check({tag, "_auto"}, 128'(obs[0]), 128'(expect_out(0)));
    check({tag, "_man"},  128'(obs[1]), 128'(expect_out(1)));
  endtask

  // Drive inputs on the falling edge and compare once they have settled.
  task automatic drive_and_check(input bit start, input bit rnd, input string tag);
    @(negedge clk);
    init_start = start;
    if (rnd) randomize_lsu();
    #1;
    check_both(tag);
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
  endtask

  task automatic step(input bit start, input bit rnd, input string tag);
    drive_and_check(start, rnd, tag);
    clock_edge();
  endtask

  initial begin
    model_reset();

    // Reset held: outputs quiet, LSU stalled, not busy.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "rst_hold");
    #2 rst_l = 1'b1;

    // Single RST cycle after release.
    step(1'b0, 1'b1, "rst_cycle");

    // LSU holds a write to 0x10 and a read for the whole auto sweep;
    // the manual instance forwards them immediately.
    l_wren  = 1'b1;
    l_wa_lo = DB'(8'h10);
    l_wd_lo = FW'(32'h12345);
    l_rden  = 1'b1;
    l_ra_lo = DB'(8'h20);
    drive_and_check(1'b0, 1'b0, "sweep1_c0");
    check("man_wr_pass", 128'({d_wren[1], d_wa_lo[1], d_wd_lo[1]}),
          128'({1'b1, DB'(8'h10), FW'(32'h12345)}));
    check("auto_rd_blocked", 128'({d_rden[0], d_stall[0]}), 128'(2'b01));
    clock_edge();
    for (int i = 1; i < NSWEEP; i++) step(1'b0, 1'b0, "sweep1");

    // First DONE cycle: held read now reaches the wrapper, done is set.
    drive_and_check(1'b0, 1'b0, "done1");
    check("held_rd_done", 128'({d_rden[0], d_ra_lo[0], d_done[0]}),
          128'({1'b1, DB'(8'h20), 1'b1}));
    clock_edge();

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "pass_rand");

    // Restart from DONE (auto) and IDLE (manual); init_start in sweep cycle 2
    // must not restart or extend the sweep.
    step(1'b1, 1'b1, "start2");
    step(1'b0, 1'b1, "sweep2");
    step(1'b0, 1'b1, "sweep2");
    step(1'b1, 1'b1, "sweep2_restart_ign");
    for (int i = 0; i < NSWEEP + 3; i++) step(1'b0, 1'b1, "sweep2");

    // Reset in sweep cycle 3, then the full sweep repeats from 0.
    step(1'b1, 1'b1, "start3");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "sweep3");
    #2 rst_l = 1'b0;
    model_reset();
    #1 check_both("mid_rst_async");
    check("mid_rst_done_clr", 128'({d_done[0], d_busy[0], d_stall[0]}), 128'(3'b001));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, "mid_rst_hold");
    #2 rst_l = 1'b1;
    for (int i = 0; i < NSWEEP + 4; i++) step(1'b0, 1'b1, "resweep");

    // Random traffic with occasional init requests.
    for (int i = 0; i < 120; i++)
      step(($urandom_range(0, 9) == 0), 1'b1, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
